// File: rtl/ctrl_pipe_mc.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pipe_mc
//  Purpose  : E/M/W control-bundle pipeline with per-stage valid bits.
//             Multi-cycle Execute ops hold E for MC_LAT cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe_mc #(
    parameter int CTRL_W = 12,
    parameter int MC_LAT = 4,
    parameter int CNT_W  = $clog2(MC_LAT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrlD,
    input  logic              validD,
    input  logic              mcD,
    input  logic              flushE,
    output logic [CTRL_W-1:0] ctrlE,
    output logic [CTRL_W-1:0] ctrlM,
    output logic [CTRL_W-1:0] ctrlW,
    output logic              validE,
    output logic              validM,
    output logic              validW,
    output logic              mcE,
    output logic              mc_busy,
    output logic              mc_done
);

    // Counter preload: the first E cycle is counted, so MC_LAT-1 more remain.
    localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(MC_LAT - 1);

    logic [CTRL_W-1:0] r_ctrlE;
    logic [CTRL_W-1:0] r_ctrlM;
    logic [CTRL_W-1:0] r_ctrlW;
    logic              r_validE;
    logic              r_validM;
    logic              r_validW;
    logic              r_mcE;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_cnt_zero;
    logic              w_busy;
    logic              w_bubble_in;

    assign w_cnt_zero  = (r_cnt == '0);
    assign w_busy      = r_validE & r_mcE & ~w_cnt_zero;
    assign w_bubble_in = flushE | ~validD;

    // Execute stage: hold while busy, otherwise bubble or load from Decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrlE  <= '0;
            r_validE <= 1'b0;
            r_mcE    <= 1'b0;
            r_cnt    <= '0;
        end else if (w_busy) begin
            r_cnt    <= r_cnt - CNT_W'(1);
        end else if (w_bubble_in) begin
            r_ctrlE  <= '0;
            r_validE <= 1'b0;
            r_mcE    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_ctrlE  <= ctrlD;
            r_validE <= 1'b1;
            r_mcE    <= mcD;
            r_cnt    <= mcD ? c_CNT_LOAD : '0;
        end
    end

    // Memory stage takes bubbles while E is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrlM  <= '0;
            r_validM <= 1'b0;
        end else if (w_busy) begin
            r_ctrlM  <= '0;
            r_validM <= 1'b0;
        end else begin
            r_ctrlM  <= r_ctrlE;
            r_validM <= r_validE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrlW  <= '0;
            r_validW <= 1'b0;
        end else begin
            r_ctrlW  <= r_ctrlM;
            r_validW <= r_validM;
        end
    end

    assign ctrlE   = r_ctrlE;
    assign ctrlM   = r_ctrlM;
    assign ctrlW   = r_ctrlW;
    assign validE  = r_validE;
    assign validM  = r_validM;
    assign validW  = r_validW;
    assign mcE     = r_mcE;
    assign mc_busy = w_busy;
    assign mc_done = r_validE & r_mcE & w_cnt_zero;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_pipe_mc
//  Purpose  : Directed self-checking bench for ctrl_pipe_mc (MC_LAT=4 and 1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe_mc;

    logic        clk;
    logic        reset;
    logic [11:0] ctrlD;
    logic        validD;
    logic        mcD;
    logic        flushE;

    logic [11:0] ctrlE, ctrlM, ctrlW;
    logic        validE, validM, validW, mcE, mc_busy, mc_done;
    logic [11:0] ctrlE1, ctrlM1, ctrlW1;
    logic        validE1, validM1, validW1, mcE1, mc_busy1, mc_done1;

    int n_chk = 0;
    int n_err = 0;
    logic [41:0] exp;

    ctrl_pipe_mc #(.CTRL_W(12), .MC_LAT(4)) u_dut (
        .clk(clk), .reset(reset), .ctrlD(ctrlD), .validD(validD), .mcD(mcD), .flushE(flushE),
        .ctrlE(ctrlE), .ctrlM(ctrlM), .ctrlW(ctrlW),
        .validE(validE), .validM(validM), .validW(validW),
        .mcE(mcE), .mc_busy(mc_busy), .mc_done(mc_done)
    );

    ctrl_pipe_mc #(.CTRL_W(12), .MC_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .ctrlD(ctrlD), .validD(validD), .mcD(mcD), .flushE(flushE),
        .ctrlE(ctrlE1), .ctrlM(ctrlM1), .ctrlW(ctrlW1),
        .validE(validE1), .validM(validM1), .validW(validW1),
        .mcE(mcE1), .mc_busy(mc_busy1), .mc_done(mc_done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ctrlE,validE,mcE, ctrlM,validM, ctrlW,validW, mc_busy,mc_done}
    function automatic logic [41:0] snap();
        return {ctrlE, validE, mcE, ctrlM, validM, ctrlW, validW, mc_busy, mc_done};
    endfunction

    function automatic logic [41:0] snap1();
        return {ctrlE1, validE1, mcE1, ctrlM1, validM1, ctrlW1, validW1, mc_busy1, mc_done1};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; ctrlD = 12'hABC; validD = 1'b1; mcD = 1'b1; flushE = 1'b0;
        #3;
        exp = '0;
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL reset_hold: got %h want %h", snap(), exp); end
        n_chk++; if (snap1() !== exp) begin n_err++; $display("FAIL reset_hold_lat1: got %h want %h", snap1(), exp); end
        tick();
        validD = 1'b0; mcD = 1'b0;
        reset = 1'b1;
        #1;
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL reset_release: got %h want %h", snap(), exp); end
        tick();
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL reset_idle_edge: got %h want %h", snap(), exp); end
    endtask

    task automatic test_single();
        validD = 1'b1; mcD = 1'b0; flushE = 1'b0;
        ctrlD = 12'hA5A; tick();
        exp = {12'hA5A, 2'b10, 12'h000, 1'b0, 12'h000, 1'b0, 2'b00};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL single_1: got %h want %h", snap(), exp); end
        ctrlD = 12'h123; tick();
        exp = {12'h123, 2'b10, 12'hA5A, 1'b1, 12'h000, 1'b0, 2'b00};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL single_2: got %h want %h", snap(), exp); end
        ctrlD = 12'h0F0; tick();
        exp = {12'h0F0, 2'b10, 12'h123, 1'b1, 12'hA5A, 1'b1, 2'b00};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL single_3: got %h want %h", snap(), exp); end
        validD = 1'b0; ctrlD = 12'h999; tick();
        exp = {12'h000, 2'b00, 12'h0F0, 1'b1, 12'h123, 1'b1, 2'b00};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL single_4: got %h want %h", snap(), exp); end
        tick();
        exp = {12'h000, 2'b00, 12'h000, 1'b0, 12'h0F0, 1'b1, 2'b00};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL single_5: got %h want %h", snap(), exp); end
        tick();
        exp = '0;
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL single_drain: got %h want %h", snap(), exp); end
    endtask

    task automatic test_flush();
        validD = 1'b1; mcD = 1'b0; flushE = 1'b0; ctrlD = 12'h0AA; tick();
        ctrlD = 12'hFFF; flushE = 1'b1; tick();
        exp = {12'h000, 2'b00, 12'h0AA, 1'b1, 12'h000, 1'b0, 2'b00};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL flush_E: got %h want %h", snap(), exp); end
        flushE = 1'b0; validD = 1'b0; tick();
        exp = {12'h000, 2'b00, 12'h000, 1'b0, 12'h0AA, 1'b1, 2'b00};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL flush_M: got %h want %h", snap(), exp); end
        tick();
        exp = '0;
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL flush_W: got %h want %h", snap(), exp); end
    endtask

    // Includes flushE and a new ctrlD while E is held; both must be ignored.
    task automatic test_mc();
        logic [41:0] hold;
        hold = {12'h801, 2'b11, 12'h000, 1'b0, 12'h000, 1'b0, 2'b10};
        validD = 1'b1; mcD = 1'b1; flushE = 1'b0; ctrlD = 12'h801; tick();
        exp = hold;
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL mc_edge1: got %h want %h", snap(), exp); end
        flushE = 1'b1; ctrlD = 12'h777; mcD = 1'b0; tick();
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL mc_edge2_flush_ignored: got %h want %h", snap(), exp); end
        tick();
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL mc_edge3: got %h want %h", snap(), exp); end
        tick();
        exp = {12'h801, 2'b11, 12'h000, 1'b0, 12'h000, 1'b0, 2'b01};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL mc_edge4_done: got %h want %h", snap(), exp); end
        flushE = 1'b0; validD = 1'b0; tick();
        exp = {12'h000, 2'b00, 12'h801, 1'b1, 12'h000, 1'b0, 2'b00};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL mc_edge5_M: got %h want %h", snap(), exp); end
        tick();
        exp = {12'h000, 2'b00, 12'h000, 1'b0, 12'h801, 1'b1, 2'b00};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL mc_edge6_W: got %h want %h", snap(), exp); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] busy_pat;
        logic [7:0] done_pat;
        busy_pat = '0; done_pat = '0;
        validD = 1'b1; mcD = 1'b1; flushE = 1'b0; ctrlD = 12'h801;
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) ctrlD = 12'h802;
            if (i == 6) begin validD = 1'b0; mcD = 1'b0; end
            tick();
            busy_pat = {busy_pat[6:0], mc_busy};
            done_pat = {done_pat[6:0], mc_done};
            if (i == 5) begin
                exp = {12'h802, 2'b11, 12'h801, 1'b1, 12'h000, 1'b0, 2'b10};
                n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL b2b_second_enter: got %h want %h", snap(), exp); end
            end
        end
        n_chk++; if (busy_pat !== 8'b1110_1110) begin n_err++; $display("FAIL b2b_busy_pattern: got %b want %b", busy_pat, 8'b1110_1110); end
        n_chk++; if (done_pat !== 8'b0001_0001) begin n_err++; $display("FAIL b2b_done_pattern: got %b want %b", done_pat, 8'b0001_0001); end
        tick(); tick();
        exp = {12'h000, 2'b00, 12'h000, 1'b0, 12'h802, 1'b1, 2'b00};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL b2b_second_W: got %h want %h", snap(), exp); end
        tick();
    endtask

    task automatic test_reset_mid_hold();
        validD = 1'b1; mcD = 1'b1; flushE = 1'b0; ctrlD = 12'h801;
        tick(); tick();
        #2;
        reset = 1'b0; ctrlD = 12'h055; mcD = 1'b0; validD = 1'b1;
        #1;
        exp = '0;
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL rstmid_async_clear: got %h want %h", snap(), exp); end
        @(negedge clk);
        reset = 1'b1;
        tick();
        exp = {12'h055, 2'b10, 12'h000, 1'b0, 12'h000, 1'b0, 2'b00};
        n_chk++; if (snap() !== exp) begin n_err++; $display("FAIL rstmid_first_load: got %h want %h", snap(), exp); end
        validD = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_mc_lat1();
        validD = 1'b1; mcD = 1'b1; flushE = 1'b0; ctrlD = 12'h3C3; tick();
        exp = {12'h3C3, 2'b11, 12'h000, 1'b0, 12'h000, 1'b0, 2'b01};
        n_chk++; if (snap1() !== exp) begin n_err++; $display("FAIL lat1_done_no_busy: got %h want %h", snap1(), exp); end
        validD = 1'b0; mcD = 1'b0; tick();
        exp = {12'h000, 2'b00, 12'h3C3, 1'b1, 12'h000, 1'b0, 2'b00};
        n_chk++; if (snap1() !== exp) begin n_err++; $display("FAIL lat1_to_M: got %h want %h", snap1(), exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_flush();
        test_mc();
        test_back_to_back();
        test_reset_mid_hold();
        test_mc_lat1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
